// File: rtl/alpu_pkg.sv
// rtl/alpu_pkg.sv - opcodes, ALPU control words and sequencer states
package alpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_ADD2 = 4'd10,
    OP_ADC2 = 4'd11
  } opcode_e;

  localparam logic [7:0] CTRL_ADD  = 8'h2C;
  localparam logic [7:0] CTRL_SUB  = 8'hAC;
  localparam logic [7:0] CTRL_AND  = 8'h22;
  localparam logic [7:0] CTRL_OR   = 8'h32;
  localparam logic [7:0] CTRL_XOR  = 8'h04;
  localparam logic [7:0] CTRL_NOT  = 8'h44;
  localparam logic [7:0] CTRL_NAND = 8'h23;
  localparam logic [7:0] CTRL_NOR  = 8'h33;
  localparam logic [7:0] CTRL_XNOR = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_LO = 2'd1,
    ST_EXEC_HI = 2'd2
  } state_e;

endpackage

// File: rtl/alpu_op_decode.sv
// rtl/alpu_op_decode.sv - opcode to ALPU control word and operation class
module alpu_op_decode
  import alpu_pkg::*;
(
  input  logic [3:0] op_code,
  output logic [7:0] ctrl,
  output logic       is_arith,
  output logic       is_double,
  output logic       use_cin,
  output logic       illegal
);

  always_comb begin
    ctrl      = CTRL_ADD;
    is_arith  = 1'b0;
    is_double = 1'b0;
    use_cin   = 1'b0;
    illegal   = 1'b0;
    case (opcode_e'(op_code))
      OP_ADD:  is_arith = 1'b1;
      OP_ADC:  begin is_arith = 1'b1; use_cin = 1'b1; end
      OP_SUB:  begin is_arith = 1'b1; ctrl = CTRL_SUB; end
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_XOR:  ctrl = CTRL_XOR;
      OP_NOT:  ctrl = CTRL_NOT;
      OP_NAND: ctrl = CTRL_NAND;
      OP_NOR:  ctrl = CTRL_NOR;
      OP_XNOR: ctrl = CTRL_XNOR;
      OP_ADD2: begin is_arith = 1'b1; is_double = 1'b1; end
      OP_ADC2: begin is_arith = 1'b1; is_double = 1'b1; use_cin = 1'b1; end
      default: begin ctrl = 8'h00; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alpu_issue_ctrl.sv
// rtl/alpu_issue_ctrl.sv - request sequencer for the combinational ALPU datapath
module alpu_issue_ctrl
  import alpu_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [3:0]             op_code,
  input  logic [2*REG_WIDTH-1:0] op_a,
  input  logic [2*REG_WIDTH-1:0] op_b,
  input  logic                   op_cin,
  input  logic [TAG_WIDTH-1:0]   op_tag,
  output logic [REG_WIDTH-1:0]   alpu_a,
  output logic [REG_WIDTH-1:0]   alpu_b,
  output logic [7:0]             alpu_ctrl,
  output logic                   alpu_cin,
  input  logic [REG_WIDTH-1:0]   alpu_out,
  input  logic                   alpu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*REG_WIDTH-1:0] res_data,
  output logic                   res_cout,
  output logic                   res_err,
  output logic [TAG_WIDTH-1:0]   res_tag
);

  state_e                 state, state_nxt;
  logic [3:0]             code_q;
  logic [REG_WIDTH-1:0]   a_hi_q, b_hi_q, lo_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [3:0]             dec_code;
  logic [7:0]             dec_ctrl;
  logic                   dec_arith, dec_double, dec_use_cin, dec_illegal;
  logic                   accept;

  assign op_ready = !reset && (state == ST_IDLE) && (!res_valid || res_ready);
  assign accept   = op_valid && op_ready;

  // In IDLE the decoder looks at the incoming request, otherwise at the latched one.
  assign dec_code = (state == ST_IDLE) ? op_code : code_q;

  alpu_op_decode u_decode (
    .op_code   (dec_code),
    .ctrl      (dec_ctrl),
    .is_arith  (dec_arith),
    .is_double (dec_double),
    .use_cin   (dec_use_cin),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept && !dec_illegal) state_nxt = ST_EXEC_LO;
      ST_EXEC_LO: state_nxt = dec_double ? ST_EXEC_HI : ST_IDLE;
      ST_EXEC_HI: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_cout  <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      alpu_a    <= '0;
      alpu_b    <= '0;
      alpu_ctrl <= 8'h00;
      alpu_cin  <= 1'b0;
      code_q    <= '0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      lo_q      <= '0;
      tag_q     <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && dec_illegal) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_tag   <= op_tag;
          end else if (accept) begin
            code_q    <= op_code;
            a_hi_q    <= op_a[2*REG_WIDTH-1:REG_WIDTH];
            b_hi_q    <= op_b[2*REG_WIDTH-1:REG_WIDTH];
            tag_q     <= op_tag;
            alpu_a    <= op_a[REG_WIDTH-1:0];
            alpu_b    <= op_b[REG_WIDTH-1:0];
            alpu_ctrl <= dec_ctrl;
            alpu_cin  <= dec_use_cin & op_cin;
          end
        end
        ST_EXEC_LO: begin
          if (dec_double) begin
            // Second pass: high words, carry chained from the low pass.
            lo_q      <= alpu_out;
            alpu_a    <= a_hi_q;
            alpu_b    <= b_hi_q;
            alpu_cin  <= alpu_cout;
            alpu_ctrl <= CTRL_ADD;
          end else begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= {{REG_WIDTH{1'b0}}, alpu_out};
            res_cout  <= dec_arith & alpu_cout;
            res_tag   <= tag_q;
          end
        end
        ST_EXEC_HI: begin
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= {alpu_out, lo_q};
          res_cout  <= alpu_cout;
          res_tag   <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alpu_issue_ctrl.sv
// tb/tb_alpu_issue_ctrl.sv - scoreboard bench for alpu_issue_ctrl with an ALPU model
module tb_alpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_code = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        op_cin = 1'b0;
  logic [3:0]  op_tag = 4'd0;
  logic [15:0] alpu_a, alpu_b, alpu_out;
  logic [7:0]  alpu_ctrl;
  logic        alpu_cin, alpu_cout;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_cout, res_err;
  logic [3:0]  res_tag;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int rr_mode = 1;

  typedef struct {
    logic [31:0] data;
    logic        cout;
    logic        err;
    logic [3:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  alpu_issue_ctrl #(.REG_WIDTH(16), .TAG_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_tag(op_tag),
    .alpu_a(alpu_a), .alpu_b(alpu_b), .alpu_ctrl(alpu_ctrl), .alpu_cin(alpu_cin),
    .alpu_out(alpu_out), .alpu_cout(alpu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_err(res_err), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  // Stand-in for alpu_comb; logic ops produce a junk carry the sequencer must mask.
  logic [16:0] alu_s;
  always_comb begin
    alu_s = 17'd0;
    case (alpu_ctrl)
      8'h2C:   alu_s = {1'b0, alpu_a} + {1'b0, alpu_b} + {16'd0, alpu_cin};
      8'hAC:   alu_s = {1'b0, alpu_b} + {1'b0, ~alpu_a} + 17'd1;
      8'h22:   alu_s[15:0] = alpu_a & alpu_b;
      8'h32:   alu_s[15:0] = alpu_a | alpu_b;
      8'h04:   alu_s[15:0] = alpu_a ^ alpu_b;
      8'h44:   alu_s[15:0] = ~alpu_a;
      8'h23:   alu_s[15:0] = ~(alpu_a & alpu_b);
      8'h33:   alu_s[15:0] = ~(alpu_a | alpu_b);
      8'h05:   alu_s[15:0] = ~(alpu_a ^ alpu_b);
      default: alu_s[15:0] = 16'hDEAD;
    endcase
    alpu_out  = alu_s[15:0];
    alpu_cout = (alpu_ctrl == 8'h2C || alpu_ctrl == 8'hAC) ? alu_s[16] : ^alu_s[15:0];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: what each opcode means arithmetically, plus its latency in edges.
  function automatic exp_t model(logic [3:0] code, logic [31:0] a, logic [31:0] b,
                                 logic cin, logic [3:0] tag, int acc);
    exp_t e;
    logic [16:0] s;
    logic [32:0] d;
    e.data = 32'd0; e.cout = 1'b0; e.err = 1'b0; e.tag = tag; e.lat = 2; e.acc = acc;
    case (code)
      4'd0:  begin s = a[15:0] + b[15:0] + 17'd0; e.data = {16'd0, s[15:0]}; e.cout = s[16]; end
      4'd1:  begin s = a[15:0] + b[15:0] + {16'd0, cin}; e.data = {16'd0, s[15:0]}; e.cout = s[16]; end
      4'd2:  begin e.data = {16'd0, 16'(b[15:0] - a[15:0])}; e.cout = (b[15:0] >= a[15:0]); end
      4'd3:  e.data = {16'd0, a[15:0] & b[15:0]};
      4'd4:  e.data = {16'd0, a[15:0] | b[15:0]};
      4'd5:  e.data = {16'd0, a[15:0] ^ b[15:0]};
      4'd6:  e.data = {16'd0, ~a[15:0]};
      4'd7:  e.data = {16'd0, ~(a[15:0] & b[15:0])};
      4'd8:  e.data = {16'd0, ~(a[15:0] | b[15:0])};
      4'd9:  e.data = {16'd0, ~(a[15:0] ^ b[15:0])};
      4'd10: begin d = a + b + 33'd0; e.data = d[31:0]; e.cout = d[32]; e.lat = 3; end
      4'd11: begin d = a + b + {32'd0, cin}; e.data = d[31:0]; e.cout = d[32]; e.lat = 3; end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [3:0] tag, input bit expect_res,
                      output int waits);
    waits = 0;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; op_cin = cin; op_tag = tag;
    #1;
    while (!op_ready) begin
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        op_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    if (expect_res) sbq.push_back(model(code, a, b, cin, tag, cycle));
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((sbq.size() != 0 || res_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      res_ready = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end
  end

  initial begin
    bit prev_v = 1'b0;
    bit cons, was_rst;
    logic [31:0] hd;
    logic [3:0] ht;
    exp_t e;
    forever begin
      @(posedge clk);
      cycle++;
      cons = res_valid && res_ready;
      was_rst = reset;
      #1;
      if (!was_rst) begin
        if (res_valid && (!prev_v || cons)) begin
          if (sbq.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_cout", 32'(res_cout), 32'(e.cout));
            chk("res_err", 32'(res_err), 32'(e.err));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
            chk("latency", 32'(cycle - e.acc), 32'(e.lat));
          end
          hd = res_data; ht = res_tag;
        end else if (res_valid) begin
          chk("hold_data", res_data, hd);
          chk("hold_tag", 32'(res_tag), 32'(ht));
          if (!res_ready) chk("op_ready_bp", 32'(op_ready), 32'd0);
        end
      end
      prev_v = res_valid;
    end
  end

  initial begin
    int w;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alpu_ctrl", 32'(alpu_ctrl), 32'd0);
    reset = 1'b0;

    send(4'd0, 32'h0000_0003, 32'h0000_0004, 1'b0, 4'h1, 1'b1, w);
    send(4'd1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 4'h2, 1'b1, w);
    send(4'd2, 32'h0000_0003, 32'h0000_000A, 1'b0, 4'h3, 1'b1, w);
    send(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 4'h4, 1'b1, w);
    send(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 4'h5, 1'b1, w);
    send(4'd8, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 4'h6, 1'b1, w);
    send(4'd6, 32'h0000_1234, 32'h0000_5555, 1'b0, 4'h7, 1'b1, w);
    send(4'd10, 32'h0001_FFFF, 32'h0000_0001, 1'b1, 4'h8, 1'b1, w);
    @(posedge clk);
    #1;
    chk("exec_hi_alpu_cin", 32'(alpu_cin), 32'd1);
    chk("exec_hi_alpu_a", 32'(alpu_a), 32'h0001);
    wait_drained("drain_directed");

    rr_mode = 0;
    send(4'd0, 32'h0000_1111, 32'h0000_2222, 1'b0, 4'h9, 1'b1, w);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); n++; end
    chk("bp_result_seen", 32'(res_valid), 32'd1);
    repeat (5) @(posedge clk);
    rr_mode = 1;
    send(4'd5, 32'h0000_00FF, 32'h0000_0F0F, 1'b0, 4'hA, 1'b1, w);
    chk("drain_accept_same_edge", 32'(w), 32'd0);
    wait_drained("drain_bp");

    send(4'd13, 32'h0000_1234, 32'h0000_5678, 1'b0, 4'hB, 1'b1, w);
    wait_drained("drain_illegal");

    send(4'd10, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 4'hC, 1'b0, w);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_res_err", 32'(res_err), 32'd0);
    chk("rst_mid_res_cout", 32'(res_cout), 32'd0);
    chk("rst_mid_res_data", res_data, 32'd0);
    chk("rst_mid_res_tag", 32'(res_tag), 32'd0);
    chk("rst_mid_alpu_a", 32'(alpu_a), 32'd0);
    chk("rst_mid_alpu_b", 32'(alpu_b), 32'd0);
    chk("rst_mid_alpu_ctrl", 32'(alpu_ctrl), 32'd0);
    chk("rst_mid_alpu_cin", 32'(alpu_cin), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_result", 32'(res_valid), 32'd0);
    send(4'd0, 32'h0000_0003, 32'h0000_0004, 1'b0, 4'hD, 1'b1, w);
    wait_drained("drain_after_reset");

    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom), 4'($urandom), 1'b1, w);
    end
    rr_mode = 1;
    wait_drained("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alpu_issue_ctrl.md
Name: alpu_issue_ctrl

Overview:
- Sequencing front-end for the combinational ALPU datapath (alpu_comb), which is instantiated in the parent.
- Accepts operation requests on a valid/ready channel and decodes each opcode into the 8-bit ALPU control word.
- Drives registered operands, ctrl and cin to the ALPU, then captures out/cout.
- Chains two ALPU passes for double-width adds and returns results on a valid/ready channel with backpressure.

Parameters:
- REG_WIDTH, 16: ALPU word width; operand and result buses are 2*REG_WIDTH.
- TAG_WIDTH, 4: width of the opaque request tag echoed with the result.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request valid
- op_ready  out  1  request accepted when op_valid && op_ready at a rising clk edge
- op_code  in  4  opcode (see Behaviour)
- op_a  in  2*REG_WIDTH  operand A; single-word ops use [REG_WIDTH-1:0]
- op_b  in  2*REG_WIDTH  operand B
- op_cin  in  1  carry-in for ADC and ADC2
- op_tag  in  TAG_WIDTH  request tag
- alpu_a  out  REG_WIDTH  to ALPU a
- alpu_b  out  REG_WIDTH  to ALPU b
- alpu_ctrl  out  8  to ALPU ctrl
- alpu_cin  out  1  to ALPU cin
- alpu_out  in  REG_WIDTH  from ALPU out
- alpu_cout  in  1  from ALPU cout
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  2*REG_WIDTH  result; upper half zero for single-word ops
- res_cout  out  1  final carry out; 0 for logic ops
- res_err  out  1  illegal opcode flag
- res_tag  out  TAG_WIDTH  echoed op_tag

Behaviour:
- Opcodes and ctrl words:
  - 0 ADD, ctrl 0x2C, cin 0.
  - 1 ADC, ctrl 0x2C, cin op_cin.
  - 2 SUB, ctrl 0xAC, cin 0; result = b - a.
  - 3 AND 0x22; 4 OR 0x32; 5 XOR 0x04; 6 NOT 0x44 (~a, b ignored); 7 NAND 0x23; 8 NOR 0x33; 9 XNOR 0x05. Logic ops drive cin 0.
  - 10 ADD2 and 11 ADC2: double-width add, two passes of ctrl 0x2C.
  - 12-15 illegal.
- States: IDLE, EXEC_LO, EXEC_HI.
- op_ready = (state==IDLE) && (!res_valid || res_ready). It is combinational and does not depend on op_valid.
- On accept:
  - Latch op_code, op_a, op_b, op_cin and op_tag.
  - Drive alpu_a/b with the low words, alpu_ctrl from decode, and alpu_cin per opcode; all are registered.
  - Go to EXEC_LO.
- Illegal opcode: stay in IDLE. At the accept edge load res_valid=1, res_err=1, res_data=0, res_cout=0 (latency 1).
- EXEC_LO, single-word op: at the edge, res_data={0,alpu_out}, res_cout = alpu_cout for arithmetic else 0, res_err=0, res_valid=1; go to IDLE. Latency is 2 edges from accept.
- EXEC_LO, ADD2/ADC2: store alpu_out as the low word. Drive the high words, alpu_cin = alpu_cout, ctrl 0x2C; go to EXEC_HI.
- EXEC_HI: res_data={alpu_out, low word}, res_cout=alpu_cout, res_valid=1; go to IDLE. Latency is 3 edges from accept.
- Result handshake:
  - res_* hold stable while res_valid && !res_ready.
  - res_valid clears at the edge where res_ready=1, unless a new result loads at the same edge.
  - A result drained and a new op accepted at the same edge is legal, giving throughput of 1 single-word op per 2 cycles.
- alpu_* outputs in IDLE: keep their last value. Consumers must ignore them.
- Reset has priority over all events, including mid-operation. At the reset edge:
  - state=IDLE, res_valid=0, res_err=0, res_cout=0.
  - res_data=0, res_tag=0, alpu_a=alpu_b=0, alpu_ctrl=0x00, alpu_cin=0.
  - Any in-flight op is dropped and no result is produced.
  - op_ready is low during reset.

Decomposition:
- Package alpu_pkg holds:
  - the opcode enum (4 bits);
  - the localparam ctrl constants (CTRL_ADD=0x2C, CTRL_SUB=0xAC, CTRL_AND=0x22, CTRL_OR=0x32, CTRL_XOR=0x04, CTRL_NOT=0x44, CTRL_NAND=0x23, CTRL_NOR=0x33, CTRL_XNOR=0x05);
  - the state enum.
- Sub-module alpu_op_decode (combinational) maps opcode to {ctrl, is_arith, is_double, use_cin, illegal}.

Test Plan:
- ADD a=0x0003, b=0x0004, res_ready=1 → res_valid 2 edges after accept, res_data=0x0000_0007, res_cout=0, tag echoed.
- ADC a=0xFFFF, b=0x0000, op_cin=1 → res_data=0x0000_0000, res_cout=1. Also: SUB a=3, b=10 → res_data=0x0007.
- AND a=0xF0F0, b=0xFF00 → 0xF000; OR → 0xFFF0; NOR → 0x000F; NOT a=0x1234 → 0xEDCB; res_cout=0 on all.
- ADD2 a=0x0001_FFFF, b=0x0000_0001 → result 3 edges after accept, res_data=0x0002_0000, res_cout=0. Also check alpu_cin=1 during EXEC_HI.
- Backpressure: hold res_ready=0 for 5 cycles after the result → res_* stable and op_ready=0. Raise res_ready with op_valid=1 → drain and accept on the same edge.
- Illegal op_code=13 → res_err=1, res_data=0, 1-edge latency. Assert reset during EXEC_HI of an ADD2 → no result, all outputs at reset values, next op completes normally.
